io_bus_responder: RTL and testbench

Memory-mapped peripheral answering the core's data-memory bus (write strobe, 8-bit address, 16-bit write data, registered 16-bit read data) for a 4-word window at the top of data space. It holds the LED output register and a 16-bit prescaled interval timer with a sticky expiry flag. The core's data RAM and this block share one address bus; the core selects between their read data with `o_hit`.

---
 rtl/io_bus_responder.sv | 202 ++++++++++++++++++++
 tb/tb_io_bus_responder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_responder.sv
// io_bus_responder: LED register and prescaled interval timer on the data bus.
// Ports: i_clk/i_reset_n (sync, active-low), i_load/i_addr/i_data write side,
//   o_data/o_hit registered read side, o_leds, o_timer_flag (sticky expiry).
// Optional: define IO_TIMER_EN to build COUNT/COMPARE/STATUS and the timer FSM.
module io_bus_responder #(
   parameter logic [7:0]  BASE_ADDR = 8'hFC,
   parameter int unsigned PRESCALE  = 1
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_load,
   input  logic [7:0]  i_addr,
   input  logic [15:0] i_data,
   output logic [15:0] o_data,
   output logic        o_hit,
   output logic [2:0]  o_leds,
   output logic        o_timer_flag
);

   localparam logic [1:0] OFF_LED = 2'd0;
   localparam logic [1:0] OFF_CNT = 2'd1;
   localparam logic [1:0] OFF_CMP = 2'd2;
   localparam logic [1:0] OFF_STS = 2'd3;

   logic       sel;
   logic [1:0] off;
   logic       wr_led;

   assign sel    = (i_addr[7:2] == BASE_ADDR[7:2]);
   assign off    = i_addr[1:0];
   assign wr_led = i_load && sel && (off == OFF_LED);

   // read views of the timer registers; zero when the timer is not built
   logic [15:0] rd_cnt;
   logic [15:0] rd_cmp;
   logic [15:0] rd_sts;
   logic        flag;

`ifdef IO_TIMER_EN
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

   state_e      state_q, state_d;
   logic [15:0] count_q, count_d;
   logic [15:0] cmp_q, cmp_d;
   logic [15:0] presc_q, presc_d;
   logic        en_q, en_d;
   logic        reload_q, reload_d;
   logic        exp_q, exp_d;

   logic wr_cnt;
   logic wr_cmp;
   logic wr_sts;
   logic tick;
   logic match;

   assign wr_cnt = i_load && sel && (off == OFF_CNT);
   assign wr_cmp = i_load && sel && (off == OFF_CMP);
   assign wr_sts = i_load && sel && (off == OFF_STS);

   assign tick  = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
   // match always uses the pre-write count, even when COUNT is written
   assign match = tick && (count_q == cmp_q);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q  <= ST_IDLE;
         count_q  <= '0;
         cmp_q    <= 16'hFFFF;
         presc_q  <= '0;
         en_q     <= 1'b0;
         reload_q <= 1'b0;
         exp_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         cmp_q    <= cmp_d;
         presc_q  <= presc_d;
         en_q     <= en_d;
         reload_q <= reload_d;
         exp_q    <= exp_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      cmp_d    = cmp_q;
      presc_d  = presc_q;
      en_d     = en_q;
      reload_d = reload_q;
      exp_d    = exp_q;

      case (state_q)
         ST_RUN: begin
            presc_d = tick ? '0 : presc_q + 16'd1;
            if (tick) begin
               if (match) begin
                  if (reload_q) begin
                     count_d = '0;
                  end else begin
                     state_d = ST_DONE;
                  end
               end else begin
                  count_d = count_q + 16'd1;
               end
            end
         end
         default: ;
      endcase

      // EN=1 while already running leaves the FSM and prescaler alone
      if (wr_sts) begin
         en_d     = i_data[0];
         reload_d = i_data[1];
         if (i_data[8]) begin
            exp_d = 1'b0;
         end
         if (!i_data[0]) begin
            state_d = ST_IDLE;
         end else if (state_q != ST_RUN) begin
            state_d = ST_RUN;
            presc_d = '0;
         end
      end

      // a fresh expiry beats a same-cycle clear
      if (match) begin
         exp_d = 1'b1;
      end

      if (wr_cnt) begin
         count_d = i_data;
         presc_d = '0;
      end

      if (wr_cmp) begin
         cmp_d = i_data;
      end
   end

   assign rd_cnt = count_q;
   assign rd_cmp = cmp_q;
   assign rd_sts = {7'b0, exp_q, 6'b0, reload_q, en_q};
   assign flag   = exp_q;
`else
   logic unused_w;

   assign unused_w = ^{i_data[15:3], PRESCALE};
   assign rd_cnt   = '0;
   assign rd_cmp   = '0;
   assign rd_sts   = '0;
   assign flag     = 1'b0;
`endif

   logic [2:0]  leds_q, leds_d;
   logic [15:0] rdata_q, rdata_d;
   logic        hit_q;

   always_comb begin
      leds_d = leds_q;
      if (wr_led) begin
         leds_d = i_data[2:0];
      end
   end

   // read data reflects register state before this edge's updates
   always_comb begin
      rdata_d = '0;
      if (sel) begin
         unique case (off)
            OFF_LED: rdata_d = {13'b0, leds_q};
            OFF_CNT: rdata_d = rd_cnt;
            OFF_CMP: rdata_d = rd_cmp;
            OFF_STS: rdata_d = rd_sts;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         leds_q  <= '0;
         rdata_q <= '0;
         hit_q   <= 1'b0;
      end else begin
         leds_q  <= leds_d;
         rdata_q <= rdata_d;
         hit_q   <= sel;
      end
   end

   assign o_data       = rdata_q;
   assign o_hit        = hit_q;
   assign o_leds       = leds_q;
   assign o_timer_flag = flag;

endmodule

// File: tb/tb_io_bus_responder.sv
// Bench for io_bus_responder: two instances (PRESCALE 1 and 4) on one bus,
// checked every cycle against a cycle-count model plus directed checks.
module tb_io_bus_responder;

`ifdef IO_TIMER_EN
   localparam bit TIMER = 1'b1;
`else
   localparam bit TIMER = 1'b0;
`endif

   localparam int IDLE_M = 0;
   localparam int RUN_M  = 1;
   localparam int DONE_M = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        load = 1'b0;
   logic [7:0]  addr = 8'h00;
   logic [15:0] wdata = 16'h0000;

   logic [15:0] d1_data, d4_data;
   logic        d1_hit, d4_hit;
   logic [2:0]  d1_leds, d4_leds;
   logic        d1_flag, d4_flag;

   always #5 clk = ~clk;

   io_bus_responder #(.BASE_ADDR(8'hFC), .PRESCALE(1)) u_p1 (
      .i_clk(clk), .i_reset_n(rst_n), .i_load(load),
      .i_addr(addr), .i_data(wdata), .o_data(d1_data),
      .o_hit(d1_hit), .o_leds(d1_leds), .o_timer_flag(d1_flag)
   );

   io_bus_responder #(.BASE_ADDR(8'hFC), .PRESCALE(4)) u_p4 (
      .i_clk(clk), .i_reset_n(rst_n), .i_load(load),
      .i_addr(addr), .i_data(wdata), .o_data(d4_data),
      .o_hit(d4_hit), .o_leds(d4_leds), .o_timer_flag(d4_flag)
   );

   int checks = 0;
   int failures = 0;

   int          pval[2] = '{1, 4};
   logic [15:0] m_cnt[2];
   logic [15:0] m_cmp[2];
   bit          m_en[2];
   bit          m_rl[2];
   bit          m_exp[2];
   int          m_mode[2];
   int          m_left[2];
   logic [2:0]  m_leds = 3'd0;
   logic [15:0] e_data[2];
   bit          e_hit[2];

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Model: a running timer ticks once every P cycles, counted down
   // from the moment it starts or COUNT is written.
   task automatic model_edge(input bit rst, input bit ld,
                             input logic [7:0] a, input logic [15:0] d);
      bit          s;
      bit          tick;
      bit          mt;
      logic [15:0] nc;
      int          nm;
      s = (a[7:2] == 6'h3F);
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            m_cnt[k]  = 16'h0000;
            m_cmp[k]  = 16'hFFFF;
            m_en[k]   = 1'b0;
            m_rl[k]   = 1'b0;
            m_exp[k]  = 1'b0;
            m_mode[k] = IDLE_M;
            m_left[k] = pval[k];
            e_data[k] = 16'h0000;
            e_hit[k]  = 1'b0;
         end else begin
            e_hit[k]  = s;
            e_data[k] = 16'h0000;
            if (s) begin
               case (a[1:0])
                  2'd0: e_data[k] = {13'h0, m_leds};
                  2'd1: e_data[k] = TIMER ? m_cnt[k] : 16'h0;
                  2'd2: e_data[k] = TIMER ? m_cmp[k] : 16'h0;
                  default: e_data[k] = TIMER ?
                     {7'h0, m_exp[k], 6'h0, m_rl[k], m_en[k]} : 16'h0;
               endcase
            end
            if (TIMER) begin
               tick = 1'b0;
               if (m_mode[k] == RUN_M) begin
                  m_left[k] = m_left[k] - 1;
                  tick = (m_left[k] == 0);
                  if (tick) m_left[k] = pval[k];
               end
               mt = tick && (m_cnt[k] == m_cmp[k]);
               nc = m_cnt[k];
               nm = m_mode[k];
               if (tick) begin
                  if (mt) begin
                     if (m_rl[k]) nc = 16'h0;
                     else nm = DONE_M;
                  end else begin
                     nc = m_cnt[k] + 16'd1;
                  end
               end
               if (ld && s && a[1:0] == 2'd3) begin
                  if (d[8]) m_exp[k] = 1'b0;
                  m_en[k] = d[0];
                  m_rl[k] = d[1];
                  if (!d[0]) nm = IDLE_M;
                  else if (m_mode[k] != RUN_M) begin
                     nm = RUN_M;
                     m_left[k] = pval[k];
                  end
               end
               if (mt) m_exp[k] = 1'b1;
               if (ld && s && a[1:0] == 2'd1) begin
                  nc = d;
                  m_left[k] = pval[k];
               end
               if (ld && s && a[1:0] == 2'd2) m_cmp[k] = d;
               m_cnt[k]  = nc;
               m_mode[k] = nm;
            end
         end
      end
      if (rst) m_leds = 3'd0;
      else if (ld && s && a[1:0] == 2'd0) m_leds = d[2:0];
   endtask

   task automatic compare_all();
      check("p1_data", d1_data, e_data[0]);
      check("p1_hit", {15'h0, d1_hit}, {15'h0, e_hit[0]});
      check("p1_leds", {13'h0, d1_leds}, {13'h0, m_leds});
      check("p1_flag", {15'h0, d1_flag}, {15'h0, TIMER && m_exp[0]});
      check("p4_data", d4_data, e_data[1]);
      check("p4_hit", {15'h0, d4_hit}, {15'h0, e_hit[1]});
      check("p4_leds", {13'h0, d4_leds}, {13'h0, m_leds});
      check("p4_flag", {15'h0, d4_flag}, {15'h0, TIMER && m_exp[1]});
   endtask

   task automatic cyc(input bit rst, input bit ld,
                      input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      rst_n = ~rst;
      load  = ld;
      addr  = a;
      wdata = d;
      @(posedge clk);
      model_edge(rst, ld, a, d);
      #1;
      compare_all();
   endtask

   task automatic wr(input logic [7:0] a, input logic [15:0] d);
      cyc(1'b0, 1'b1, a, d);
   endtask

   task automatic rd(input logic [7:0] a);
      cyc(1'b0, 1'b0, a, 16'h0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 8'h00, 16'h0);
   endtask

   initial begin
      logic [7:0]  ra;
      logic [15:0] rdv;
      bit          rl;
      bit          rr;

      // reset state
      do_reset(3);
      check("rst_data", d1_data, 16'h0);
      check("rst_hit", {15'h0, d1_hit}, 16'h0);
      check("rst_leds", {13'h0, d1_leds}, 16'h0);
      check("rst_flag", {15'h0, d4_flag}, 16'h0);
      rd(8'hFC);
      check("rst_led_rd", d1_data, 16'h0);
      check("rst_led_hit", {15'h0, d1_hit}, 16'h1);
      rd(8'hFD);
      check("rst_cnt_rd", d1_data, 16'h0);
      check("rst_cnt_hit", {15'h0, d1_hit}, 16'h1);
      rd(8'hFE);
      check("rst_cmp_rd", d1_data, TIMER ? 16'hFFFF : 16'h0);
      check("rst_cmp_hit", {15'h0, d1_hit}, 16'h1);
      rd(8'hFF);
      check("rst_sts_rd", d4_data, 16'h0);
      check("rst_sts_hit", {15'h0, d4_hit}, 16'h1);

      // LED and decode
      wr(8'hFC, 16'h0005);
      check("led_set", {13'h0, d1_leds}, 16'h5);
      wr(8'hFB, 16'h0002);
      check("led_hold", {13'h0, d4_leds}, 16'h5);
      rd(8'hFB);
      check("miss_hit", {15'h0, d1_hit}, 16'h0);
      check("miss_data", d1_data, 16'h0);

      // one-shot on the PRESCALE=1 instance
      wr(8'hFE, 16'd3);
      wr(8'hFD, 16'd0);
      wr(8'hFF, 16'h0001);
      rd(8'h00);
      rd(8'h00);
      rd(8'h00);
      check("os_flag_early", {15'h0, d1_flag}, 16'h0);
      rd(8'h00);
      check("os_flag_rise", {15'h0, d1_flag}, {15'h0, TIMER});
      rd(8'hFD);
      check("os_cnt", d1_data, TIMER ? 16'd3 : 16'd0);
      rd(8'h00);
      rd(8'h00);
      rd(8'hFD);
      check("os_cnt_hold", d1_data, TIMER ? 16'd3 : 16'd0);
      wr(8'hFF, 16'h0100);
      check("os_w1c", {15'h0, d1_flag}, 16'h0);

      // auto-reload on the PRESCALE=4 instance
      do_reset(1);
      wr(8'hFE, 16'd1);
      wr(8'hFF, 16'h0003);
      for (int i = 1; i <= 16; i++) begin
         if (i == 9) wr(8'hFF, 16'h0103);
         else rd(8'hFD);
         if (i == 7) check("ar_flag7", {15'h0, d4_flag}, 16'h0);
         if (i == 8) check("ar_flag8", {15'h0, d4_flag}, {15'h0, TIMER});
         if (i == 10) check("ar_clr", {15'h0, d4_flag}, 16'h0);
         if (i == 11) check("ar_cnt0", d4_data, 16'd0);
         if (i == 13) check("ar_cnt1", d4_data, TIMER ? 16'd1 : 16'd0);
         if (i == 15) check("ar_flag15", {15'h0, d4_flag}, 16'h0);
         if (i == 16) check("ar_flag16", {15'h0, d4_flag}, {15'h0, TIMER});
      end

      // wrap-around match
      do_reset(1);
      wr(8'hFE, 16'h0000);
      wr(8'hFD, 16'hFFFE);
      wr(8'hFF, 16'h0001);
      rd(8'h00);
      rd(8'h00);
      check("wrap_early", {15'h0, d1_flag}, 16'h0);
      rd(8'h00);
      check("wrap_set", {15'h0, d1_flag}, {15'h0, TIMER});

      // clear and expiry on the same edge
      do_reset(1);
      wr(8'hFE, 16'd2);
      wr(8'hFF, 16'h0003);
      rd(8'h00);
      rd(8'h00);
      wr(8'hFF, 16'h0103);
      check("w1c_vs_set", {15'h0, d1_flag}, {15'h0, TIMER});
      wr(8'hFF, 16'h0103);
      check("w1c_after", {15'h0, d1_flag}, 16'h0);

      // COUNT write on a tick edge
      do_reset(1);
      wr(8'hFF, 16'h0001);
      rd(8'h00);
      rd(8'h00);
      wr(8'hFD, 16'h1234);
      rd(8'hFD);
      check("cw_tick", d1_data, TIMER ? 16'h1234 : 16'h0);
      rd(8'hFD);
      check("cw_next", d1_data, TIMER ? 16'h1235 : 16'h0);

      // reset two ticks before the match
      do_reset(1);
      wr(8'hFE, 16'd3);
      wr(8'hFF, 16'h0001);
      for (int i = 0; i < 7; i++) rd(8'h00);
      do_reset(1);
      for (int i = 0; i < 20; i++) rd(8'h00);
      check("mid_flag", {15'h0, d4_flag}, 16'h0);
      rd(8'hFD);
      check("mid_cnt", d4_data, 16'h0);
      rd(8'hFF);
      check("mid_sts", d4_data, 16'h0);

      // randomized traffic
      do_reset(1);
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 7) < 5) ra = 8'hFC | 8'($urandom_range(0, 3));
         else ra = 8'($urandom);
         case (ra[1:0])
            2'd1: rdv = ($urandom_range(0, 1) == 1) ?
                        16'($urandom_range(0, 6)) :
                        16'hFFFF - 16'($urandom_range(0, 3));
            2'd2: rdv = 16'($urandom_range(0, 8));
            2'd3: rdv = (16'($urandom) & 16'h0103) |
                        (($urandom_range(0, 3) != 0) ? 16'h1 : 16'h0);
            default: rdv = 16'($urandom);
         endcase
         rl = ($urandom_range(0, 3) == 0);
         rr = ($urandom_range(0, 99) == 0);
         cyc(rr, rl, ra, rdv);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
